// File: rtl/rxm_mem_responder_if.sv
// Rxm Avalon-MM bundle between the TLP RX master ports (one per BAR) and the memory responder.
// Port p occupies slice p of every packed vector.
interface rxm_mem_responder_if #(
    parameter int C_NUM_PORTS  = 6,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 64
);
    logic [C_NUM_PORTS-1:0]                  RxmWrite_o;
    logic [C_NUM_PORTS-1:0]                  RxmRead_o;
    logic [C_NUM_PORTS*C_ADDR_WIDTH-1:0]     RxmAddress_o;
    logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     RxmWriteData_o;
    logic [C_NUM_PORTS*(C_DATA_WIDTH/8)-1:0] RxmByteEnable_o;
    logic [C_NUM_PORTS*7-1:0]                RxmBurstCount_o;
    logic [C_NUM_PORTS-1:0]                  RxmWaitRequest_i;
    logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     RxmReadData_i;
    logic [C_NUM_PORTS-1:0]                  RxmReadDataValid_i;

    modport master (
        output RxmWrite_o, RxmRead_o, RxmAddress_o, RxmWriteData_o,
               RxmByteEnable_o, RxmBurstCount_o,
        input  RxmWaitRequest_i, RxmReadData_i, RxmReadDataValid_i
    );

    modport slave (
        input  RxmWrite_o, RxmRead_o, RxmAddress_o, RxmWriteData_o,
               RxmByteEnable_o, RxmBurstCount_o,
        output RxmWaitRequest_i, RxmReadData_i, RxmReadDataValid_i
    );
endinterface

// File: rtl/rxm_mem_responder.sv
// Shared word memory terminating all Rxm master ports, round-robin arbitrated, burst capable.
// Optional random wait/valid injection is enabled with `define RXM_RESP_WAIT_INJ_EN.
module rxm_mem_responder #(
    parameter int C_NUM_PORTS  = 6,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_MEM_DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst,
    rxm_mem_responder_if.slave  rxm,
    output logic                Busy_i
);
    localparam int BE_W = C_DATA_WIDTH / 8;
    localparam int OFFS = $clog2(BE_W);
    localparam int IW   = $clog2(C_MEM_DEPTH);
    localparam int GW   = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            rr_q, rr_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [6:0]               cnt_q, cnt_d;
    logic [C_NUM_PORTS-1:0]   valid_q, valid_d;
    logic [C_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [C_DATA_WIDTH-1:0]  mem_q [C_MEM_DEPTH];

    logic [C_NUM_PORTS-1:0]   req;
    logic [C_NUM_PORTS-1:0]   wait_req;
    logic [GW-1:0]            sel;
    logic                     wr_en;
    logic                     stall;
    logic                     unused_addr_bits;

    function automatic logic [GW-1:0] next_port(input logic [GW-1:0] p);
        if (int'(p) == C_NUM_PORTS - 1) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [6:0] clamp_bc(input logic [6:0] bc);
        if (bc == 7'd0)  return 7'd1;
        if (bc > 7'd64)  return 7'd64;
        return bc;
    endfunction

`ifdef RXM_RESP_WAIT_INJ_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign req              = rxm.RxmWrite_o | rxm.RxmRead_o;
    assign unused_addr_bits = ^rxm.RxmAddress_o;

    // First requester at or after the round-robin pointer.
    always_comb begin
        sel = rr_q;
        for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
            if (req[(int'(rr_q) + i) % C_NUM_PORTS]) sel = GW'((int'(rr_q) + i) % C_NUM_PORTS);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        valid_d   = '0;
        rd_data_d = rd_data_q;
        wr_en     = 1'b0;
        wait_req  = '1;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = sel;
                    idx_d   = rxm.RxmAddress_o[int'(sel)*C_ADDR_WIDTH + OFFS +: IW];
                    cnt_d   = clamp_bc(rxm.RxmBurstCount_o[int'(sel)*7 +: 7]);
                    state_d = rxm.RxmWrite_o[sel] ? WR : RD_CMD;
                end
            end
            WR: begin
                if (!stall) begin
                    wait_req[grant_q] = 1'b0;
                    if (rxm.RxmWrite_o[grant_q]) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == 7'd1) begin
                            rr_d    = next_port(grant_q);
                            state_d = IDLE;
                        end
                    end
                end
            end
            RD_CMD: begin
                if (!stall) begin
                    wait_req[grant_q] = 1'b0;
                    state_d = rxm.RxmRead_o[grant_q] ? RD_DATA : IDLE;
                end
            end
            RD_DATA: begin
                if (!stall) begin
                    valid_d[grant_q] = 1'b1;
                    rd_data_d        = mem_q[idx_q];
                    idx_d            = idx_q + 1'b1;
                    cnt_d            = cnt_q - 1'b1;
                    if (cnt_q == 7'd1) begin
                        rr_d    = next_port(grant_q);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= only; blocking here would race with readers of *_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: the array is deliberately not reset so it maps onto block RAM and survives a mid-burst reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (rxm.RxmByteEnable_o[int'(grant_q)*BE_W + b])
                    mem_q[idx_q][b*8 +: 8] <= rxm.RxmWriteData_o[int'(grant_q)*C_DATA_WIDTH + b*8 +: 8];
            end
        end
    end

    assign rxm.RxmWaitRequest_i   = wait_req;
    assign rxm.RxmReadDataValid_i = valid_q;
    assign rxm.RxmReadData_i      = {C_NUM_PORTS{rd_data_q}};
    assign Busy_i                 = (state_q != IDLE);
endmodule
